// File: rtl/charli_pkg.sv
// Shared constants, types and the fixed slot-to-pin lookup for the
// charlieplexed 4-pin / 12-LED frame scheduler.
package charli_pkg;

  localparam int NUM_LED   = 12;
  localparam int NUM_PHASE = 3;
  localparam int NUM_PIN   = 4;
  localparam int LVL_W     = 2;
  localparam int IDX_W     = 4;
  localparam int SLOT_W    = 4;
  localparam int PHASE_W   = 2;
  localparam int PIN_IDX_W = 2;

  typedef struct packed {
    logic [PIN_IDX_W-1:0] hi;
    logic [PIN_IDX_W-1:0] lo;
  } pin_pair_t;

  // Each slot pairs one driven-high pin with one driven-low pin.
  function automatic pin_pair_t slot_pins(input logic [SLOT_W-1:0] slot);
    pin_pair_t p;
    case (slot)
      4'd0:    p = '{hi: 2'd2, lo: 2'd3};
      4'd1:    p = '{hi: 2'd1, lo: 2'd2};
      4'd2:    p = '{hi: 2'd0, lo: 2'd1};
      4'd3:    p = '{hi: 2'd3, lo: 2'd2};
      4'd4:    p = '{hi: 2'd2, lo: 2'd1};
      4'd5:    p = '{hi: 2'd1, lo: 2'd0};
      4'd6:    p = '{hi: 2'd1, lo: 2'd3};
      4'd7:    p = '{hi: 2'd0, lo: 2'd2};
      4'd8:    p = '{hi: 2'd3, lo: 2'd1};
      4'd9:    p = '{hi: 2'd2, lo: 2'd0};
      4'd10:   p = '{hi: 2'd0, lo: 2'd3};
      4'd11:   p = '{hi: 2'd3, lo: 2'd0};
      default: p = '{hi: 2'd2, lo: 2'd3};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/charli_scan_timer.sv
// Free-running tick/slot/phase scan counters with the frame-end strobe
// (combinational, last clock of a frame) and a registered frame-start pulse.
module charli_scan_timer
  import charli_pkg::*;
#(
  parameter int CLK_DIV_W = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [CLK_DIV_W-1:0] o_tick,
  output logic [SLOT_W-1:0]    o_slot,
  output logic [PHASE_W-1:0]   o_phase,
  output logic                 o_frame_end,
  output logic                 o_frame_start
);

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(NUM_LED - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(NUM_PHASE - 1);

  logic [CLK_DIV_W-1:0] r_tick;
  logic [SLOT_W-1:0]    r_slot;
  logic [PHASE_W-1:0]   r_phase;
  logic                 r_frame_start;
  logic                 w_tick_wrap;
  logic                 w_slot_wrap;

  assign w_tick_wrap = &r_tick;
  assign w_slot_wrap = w_tick_wrap && (r_slot == SLOT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick        <= '0;
      r_slot        <= '0;
      r_phase       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_tick <= r_tick + 1'b1;
      if (w_tick_wrap)
        r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
      if (w_slot_wrap)
        r_phase <= (r_phase == PHASE_LAST) ? '0 : r_phase + 1'b1;
      // Registered so it lines up with the first drive cycle of the frame.
      r_frame_start <= (r_tick == '0) && (r_slot == '0) && (r_phase == '0);
    end
  end

  assign o_tick        = r_tick;
  assign o_slot        = r_slot;
  assign o_phase       = r_phase;
  assign o_frame_end   = w_slot_wrap && (r_phase == PHASE_LAST);
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/charli_frame_scheduler.sv
// Charlieplexed 12-LED display driver: shadow/active frame buffers with
// tear-free commit at frame end, 3-phase PWM and per-slot dead time.
module charli_frame_scheduler
  import charli_pkg::*;
#(
  parameter int CLK_DIV_W = 13,
  parameter int DEAD_CYC  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [LVL_W-1:0]   wr_level,
  input  logic               commit,
  output logic               commit_done,
  output logic               frame_start,
  output logic [NUM_PIN-1:0] pin_out,
  output logic [NUM_PIN-1:0] pin_oe
);

  localparam logic [SLOT_W-1:0]    NUM_LED_S = SLOT_W'(NUM_LED);
  localparam logic [CLK_DIV_W-1:0] DEAD_T    = CLK_DIV_W'(DEAD_CYC);

  logic [CLK_DIV_W-1:0] w_tick;
  logic [SLOT_W-1:0]    w_slot;
  logic [PHASE_W-1:0]   w_phase;
  logic                 w_frame_end;
  logic                 w_frame_start;

  logic [LVL_W-1:0]     r_shadow [NUM_LED];
  logic [LVL_W-1:0]     r_active [NUM_LED];
  logic                 r_commit_pending;
  logic                 r_commit_done;
  logic [NUM_PIN-1:0]   r_pin_out;
  logic [NUM_PIN-1:0]   r_pin_oe;

  logic                 w_wr_acc;
  logic                 w_swap;
  logic                 w_lit;
  logic [LVL_W-1:0]     w_lvl;
  pin_pair_t            w_pins;
  logic [NUM_PIN-1:0]   w_oe_nxt;
  logic [NUM_PIN-1:0]   w_out_nxt;

  charli_scan_timer #(
    .CLK_DIV_W(CLK_DIV_W)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .o_tick       (w_tick),
    .o_slot       (w_slot),
    .o_phase      (w_phase),
    .o_frame_end  (w_frame_end),
    .o_frame_start(w_frame_start)
  );

  assign wr_ready = !r_commit_pending;
  assign w_wr_acc = wr_valid && wr_ready;
  assign w_swap   = w_frame_end && r_commit_pending;

  always_comb begin
    w_pins    = slot_pins(w_slot);
    w_lvl     = '0;
    if (w_slot < NUM_LED_S)
      w_lvl = r_active[w_slot];
    // Level L lights the LED in phases 0..L-1; dead time blanks slot start.
    w_lit     = en && (w_tick >= DEAD_T) && (w_lvl > w_phase);
    w_oe_nxt  = '0;
    w_out_nxt = '0;
    if (w_lit) begin
      w_oe_nxt[w_pins.hi]  = 1'b1;
      w_oe_nxt[w_pins.lo]  = 1'b1;
      w_out_nxt[w_pins.hi] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LED; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      // Out-of-range indices are consumed by the handshake but dropped.
      if (w_wr_acc && (wr_idx < NUM_LED_S))
        r_shadow[wr_idx] <= wr_level;
      if (w_swap)
        r_active <= r_shadow;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_commit_pending <= 1'b0;
      r_commit_done    <= 1'b0;
      r_pin_out        <= '0;
      r_pin_oe         <= '0;
    end else begin
      // A commit landing on the swap edge itself is ignored while pending.
      if (w_swap)
        r_commit_pending <= 1'b0;
      else if (commit)
        r_commit_pending <= 1'b1;
      r_commit_done <= w_swap;
      r_pin_out     <= w_out_nxt;
      r_pin_oe      <= w_oe_nxt;
    end
  end

  assign commit_done = r_commit_done;
  assign frame_start = w_frame_start;
  assign pin_out     = r_pin_out;
  assign pin_oe      = r_pin_oe;

endmodule

// File: tb/tb_charli_frame_scheduler.sv
// Bench for charli_frame_scheduler: cycle-count based reference model,
// table of single-LED frames, directed corner sequences and random traffic.
module tb_charli_frame_scheduler;

  localparam int CDW      = 3;
  localparam int DEAD     = 2;
  localparam int SLOT_CYC = 8;
  localparam int FRAME    = SLOT_CYC * 12 * 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_idx;
  logic [1:0] wr_level;
  logic       commit;
  logic       commit_done;
  logic       frame_start;
  logic [3:0] pin_out;
  logic [3:0] pin_oe;

  charli_frame_scheduler #(
    .CLK_DIV_W(CDW),
    .DEAD_CYC (DEAD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_level   (wr_level),
    .commit     (commit),
    .commit_done(commit_done),
    .frame_start(frame_start),
    .pin_out    (pin_out),
    .pin_oe     (pin_oe)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: n counts clock edges since reset release.
  int         n;
  logic [1:0] m_sh  [12];
  logic [1:0] m_act [12];
  bit         m_pend;
  int         cd_seen = 0;
  bit         rdy_before;
  int         HI [12] = '{2, 1, 0, 3, 2, 1, 1, 0, 3, 2, 0, 3};
  int         LO [12] = '{3, 2, 1, 2, 1, 0, 3, 2, 1, 0, 3, 0};

  typedef struct {
    int         idx;
    int         lvl;
    logic [3:0] oe;
    logic [3:0] out;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input bit e, input bit wv, input int idx, input int lvl, input bit cm);
    int         tk, sl, ph;
    bit         swap, acc, efs;
    logic [3:0] eo, eu;
    tk  = n % SLOT_CYC;
    sl  = (n / SLOT_CYC) % 12;
    ph  = (n / (SLOT_CYC * 12)) % 3;
    efs = (n % FRAME) == 0;
    eo  = '0;
    eu  = '0;
    if (e && tk >= DEAD && int'(m_act[sl]) > ph) begin
      eo[HI[sl]] = 1'b1;
      eo[LO[sl]] = 1'b1;
      eu[HI[sl]] = 1'b1;
    end
    swap = m_pend && ((n % FRAME) == FRAME - 1);
    acc  = wv && !m_pend;
    if (acc && idx < 12) m_sh[idx] = lvl[1:0];
    if (swap) begin
      m_act  = m_sh;
      m_pend = 1'b0;
    end else if (cm) begin
      m_pend = 1'b1;
    end
    en = e; wr_valid = wv; wr_idx = 4'(idx); wr_level = 2'(lvl); commit = cm;
    rdy_before = wr_ready;
    @(posedge clk);
    #1;
    n++;
    chk("pin_oe", pin_oe, eo);
    chk("pin_out", pin_out, eu);
    chk("frame_start", frame_start, efs);
    chk("commit_done", commit_done, swap);
    chk("wr_ready", wr_ready, !m_pend);
    if (commit_done) cd_seen++;
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b0; en = 1'b0; wr_valid = 1'b0; commit = 1'b0; wr_idx = '0; wr_level = '0;
    #1;
    chk("rst_oe", pin_oe, 0);
    chk("rst_out", pin_out, 0);
    chk("rst_cdone", commit_done, 0);
    chk("rst_fstart", frame_start, 0);
    repeat (cyc) begin
      @(posedge clk);
      #1;
      chk("rst_oe_hold", pin_oe, 0);
    end
    rst = 1'b1;
    n = 0; m_pend = 1'b0;
    for (int i = 0; i < 12; i++) begin
      m_sh[i] = '0; m_act[i] = '0;
    end
  endtask

  task automatic wait_done(input int budget, output int k);
    int c0;
    c0 = cd_seen;
    k = 0;
    while (cd_seen == c0 && k < budget) begin
      step(1, 0, 0, 0, 0);
      k++;
    end
    chk("commit_done_seen", cd_seen > c0, 1);
  endtask

  task automatic check_frame(input string nm, input int idx, input int lvl, input logic [3:0] eo,
                             input logic [3:0] eu, input bit e, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int tk, sl, ph;
      bit on;
      tk = n % SLOT_CYC;
      sl = (n / SLOT_CYC) % 12;
      ph = (n / (SLOT_CYC * 12)) % 3;
      on = e && sl == idx && ph < lvl && tk >= DEAD;
      step(e, 0, 0, 0, 0);
      chk({nm, "_oe"}, pin_oe, on ? eo : 4'b0);
      chk({nm, "_out"}, pin_out, on ? eu : 4'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    int   k, c0;
    tbl[0] = '{idx: 0,  lvl: 3, oe: 4'b1100, out: 4'b0100};
    tbl[1] = '{idx: 7,  lvl: 1, oe: 4'b0101, out: 4'b0001};
    tbl[2] = '{idx: 11, lvl: 2, oe: 4'b1001, out: 4'b1000};
    tbl[3] = '{idx: 4,  lvl: 2, oe: 4'b0110, out: 4'b0100};
    tbl[4] = '{idx: 9,  lvl: 3, oe: 4'b0101, out: 4'b0100};

    do_reset(5);
    step(1, 0, 0, 0, 0);
    chk("fstart_clock1", frame_start, 1);
    chk("ready_after_rst", wr_ready, 1);

    // Single-LED frames; write and commit share a cycle for each entry.
    for (int j = 0; j < 5; j++) begin
      if (j > 0) step(1, 1, tbl[j-1].idx, 0, 0);
      step(1, 1, tbl[j].idx, tbl[j].lvl, 1);
      wait_done(2 * FRAME, k);
      check_frame("tbl", tbl[j].idx, tbl[j].lvl, tbl[j].oe, tbl[j].out, 1, FRAME);
    end

    // Write blocked while a commit is pending; active stays untorn.
    step(1, 0, 0, 0, 1);
    chk("ready_pend", wr_ready, 0);
    c0 = cd_seen;
    k = 0;
    do begin
      step(1, 1, 3, 2, 0);
      k++;
    end while (!rdy_before && k < 2 * FRAME);
    chk("tear_write_taken", rdy_before, 1);
    chk("tear_one_done", cd_seen - c0, 1);
    check_frame("tear_dark", 9, 3, 4'b0101, 4'b0100, 1, FRAME - 1);
    step(1, 1, 9, 0, 1);
    wait_done(2 * FRAME, k);
    check_frame("tear_lit", 3, 2, 4'b1100, 4'b1000, 1, FRAME);

    // Commit on the frame-end edge while idle waits a whole frame.
    while ((n % FRAME) != FRAME - 1) step(1, 0, 0, 0, 0);
    step(1, 1, 5, 1, 1);
    chk("bnd_no_done", commit_done, 0);
    wait_done(2 * FRAME, k);
    chk("bnd_wait", k, FRAME);

    // Display disabled: pins stay off, commit still completes.
    c0 = cd_seen;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(0, 0, 0, 0, 0);
      chk("en0_oe", pin_oe, 0);
    end
    chk("en0_done", cd_seen - c0, 1);

    // Reset mid-frame drops a pending commit.
    step(1, 1, 2, 3, 1);
    do_reset(2);
    c0 = cd_seen;
    repeat (2 * FRAME) step(1, 0, 0, 0, 0);
    chk("rst_lost_commit", cd_seen - c0, 0);

    // Out-of-range indices leave every LED dark.
    step(1, 1, 13, 3, 0);
    step(1, 1, 12, 2, 0);
    step(1, 1, 15, 1, 1);
    wait_done(2 * FRAME, k);
    check_frame("badidx", 0, 0, 4'b0, 4'b0, 1, FRAME);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 8) != 0, ($urandom % 3) == 0, int'($urandom % 16),
           int'($urandom % 4), ($urandom % 40) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
